// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and helpers for the seq_divider_rx iterative divider.
// Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 256;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Divide-by-zero quotient: all ones, truncated to the operand width by the caller.
    function automatic logic [MAX_W-1:0] dbz_quotient();
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division step (shift, compare, subtract).
// Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;
    // The partial remainder is always below the divisor, so its MSB is never set.
    logic           unused_acc_msb;

    assign unused_acc_msb = acc_i[WIDTH];
    assign shifted        = {acc_i[WIDTH-1:0], quo_i[WIDTH-1]};
    assign diff           = shifted - {1'b0, div_i};
    assign ge             = (shifted >= {1'b0, div_i});
    assign acc_o          = ge ? diff : shifted;
    assign quo_o          = {quo_i[WIDTH-2:0], ge};

endmodule
`default_nettype wire

// File: rtl/seq_divider_rx.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_rx
// Purpose  : Iterative STEPS-bit-per-cycle divider with valid/ready handshakes
//            and tag pass-through. Define DIVIDER_SIGNED_EN for signed support.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider_rx
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N      = WIDTH / STEPS;
    localparam int CNT_W  = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] DBZ_QUO  = WIDTH'(dbz_quotient());

    if ((WIDTH % STEPS) != 0) begin : g_bad_steps
        $error("seq_divider_rx: WIDTH must be a multiple of STEPS");
    end
    if ((WIDTH < 2) || (WIDTH > MAX_W)) begin : g_bad_width
        $error("seq_divider_rx: WIDTH out of range");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [TAG_W-1:0] tag_q;
    logic             dbz_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_quo_q;
    logic [WIDTH-1:0] out_rem_q;
    logic             out_dbz_q;
    logic [TAG_W-1:0] out_tag_q;

    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;

    logic [WIDTH:0]   acc_chain [STEPS+1];
    logic [WIDTH-1:0] quo_chain [STEPS+1];

    assign acc_chain[0] = acc_q;
    assign quo_chain[0] = quo_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .acc_i (acc_chain[i]),
            .quo_i (quo_chain[i]),
            .div_i (div_q),
            .acc_o (acc_chain[i+1]),
            .quo_o (quo_chain[i+1])
        );
    end

    assign acc_d = acc_chain[STEPS];
    assign quo_d = quo_chain[STEPS];

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic a_neg;
    logic b_neg;
    logic ovf_in;
    logic qneg_q;
    logic rneg_q;
    logic ovf_q;
    logic out_ovf_q;

    assign a_neg   = in_signed & in_a[WIDTH-1];
    assign b_neg   = in_signed & in_b[WIDTH-1];
    assign a_mag   = a_neg ? (~in_a + 1'b1) : in_a;
    assign b_mag   = b_neg ? (~in_b + 1'b1) : in_b;
    // MIN / -1 already yields quotient MIN and remainder 0 from the magnitudes.
    assign ovf_in  = in_signed & (in_a == SMIN) & (in_b == '1);
    assign res_quo = qneg_q ? (~quo_q + 1'b1) : quo_q;
    assign res_rem = rneg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign out_ovf = out_ovf_q;
`else
    logic unused_signed;

    assign unused_signed = in_signed;
    assign a_mag         = in_a;
    assign b_mag         = in_b;
    assign res_quo       = quo_q;
    assign res_rem       = acc_q[WIDTH-1:0];
    assign out_ovf       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            tag_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_quo_q   <= '0;
            out_rem_q   <= '0;
            out_dbz_q   <= 1'b0;
            out_tag_q   <= '0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tag_q <= in_tag;
                        cnt_q <= '0;
                        div_q <= b_mag;
                        if (in_b == '0) begin
                            acc_q   <= {1'b0, in_a};
                            quo_q   <= DBZ_QUO;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
`ifdef DIVIDER_SIGNED_EN
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            ovf_q   <= 1'b0;
`endif
                        end else begin
                            acc_q   <= '0;
                            quo_q   <= a_mag;
                            dbz_q   <= 1'b0;
                            state_q <= CALC;
`ifdef DIVIDER_SIGNED_EN
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            ovf_q   <= ovf_in;
`endif
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the sign-corrected result registers.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_quo_q   <= res_quo;
                        out_rem_q   <= res_rem;
                        out_dbz_q   <= dbz_q;
                        out_tag_q   <= tag_q;
`ifdef DIVIDER_SIGNED_EN
                        out_ovf_q   <= ovf_q;
`endif
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_quo   = out_quo_q;
    assign out_rem   = out_rem_q;
    assign out_dbz   = out_dbz_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_rx
// Purpose  : Self-checking bench for seq_divider_rx (WIDTH=8, STEPS=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider_rx;

    localparam int W     = 8;
    localparam int S     = 2;
    localparam int TW    = 4;
    localparam int NSTEP = W / S;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_quo;
    logic [W-1:0]  out_rem;
    logic          out_dbz;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider_rx #(.WIDTH(W), .STEPS(S), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quo   (out_quo),
        .out_rem   (out_rem),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division from the arithmetic rules.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz, output logic ovf);
        int sa;
        int sb;
        dbz = 1'b0;
        ovf = 1'b0;
        sa  = 0;
        sb  = 0;
        if (b == 0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end
`ifdef DIVIDER_SIGNED_EN
        else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
                q   = a;
                r   = '0;
                ovf = 1'b1;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end
`endif
        else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one request and returns the number of edges from acceptance to out_valid
    // (-1 if it never came). With noise set, in_valid stays high with junk while busy.
    task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [TW-1:0] t, input bit noise, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
        @(posedge clk);
        #1;
        if (noise) begin
            in_a   = W'($urandom);
            in_b   = W'($urandom) | 8'h01;
            in_tag = TW'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if ({out_valid, out_quo, out_rem, out_dbz, out_ovf, out_tag} !== '0) begin
            $display("FAIL reset_outputs: got v=%b q=%h r=%h dbz=%b ovf=%b tag=%h, want all zero",
                     out_valid, out_quo, out_rem, out_dbz, out_ovf, out_tag);
        end else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        run_req(8'd200, 8'd7, 1'b0, 4'h5, 1'b0, lat);
        n_total++;
        if (lat !== NSTEP + 1) $display("FAIL basic_latency: got %0d want %0d", lat, NSTEP + 1);
        else n_pass++;
        n_total++;
        if ({out_quo, out_rem, out_dbz, out_ovf, out_tag} !== {8'd28, 8'd4, 1'b0, 1'b0, 4'h5})
            $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b ovf=%b tag=%h want q=28 r=4 dbz=0 ovf=0 tag=5",
                     out_quo, out_rem, out_dbz, out_ovf, out_tag);
        else n_pass++;
        drain();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL basic_drain: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_dbz();
        int lat;
        run_req(8'd13, 8'd0, 1'b0, 4'hA, 1'b0, lat);
        n_total++;
        if (lat !== 1) $display("FAIL dbz_latency: got %0d want 1", lat);
        else n_pass++;
        n_total++;
        if ({out_quo, out_rem, out_dbz, out_ovf, out_tag} !== {8'hFF, 8'd13, 1'b1, 1'b0, 4'hA})
            $display("FAIL dbz_13_0: got q=%h r=%0d dbz=%b ovf=%b tag=%h want q=ff r=13 dbz=1 ovf=0 tag=a",
                     out_quo, out_rem, out_dbz, out_ovf, out_tag);
        else n_pass++;
        drain();
        run_req(8'd99, 8'd9, 1'b0, 4'h3, 1'b0, lat);
        n_total++;
        if ({lat == NSTEP + 1, out_quo, out_rem, out_dbz} !== {1'b1, 8'd11, 8'd0, 1'b0})
            $display("FAIL dbz_next_req: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=11 r=0 dbz=0",
                     lat, out_quo, out_rem, out_dbz, NSTEP + 1);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [W+W+TW+1:0] snap;
        run_req(8'd157, 8'd12, 1'b0, 4'h9, 1'b1, lat);
        snap = {out_quo, out_rem, out_dbz, out_ovf, out_tag};
        n_total++;
        if (snap !== {8'd13, 8'd1, 1'b0, 1'b0, 4'h9})
            $display("FAIL bp_value: got %h want %h", snap, {8'd13, 8'd1, 1'b0, 1'b0, 4'h9});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if ({out_valid, in_ready} !== 2'b10)
                $display("FAIL bp_handshake[%0d]: got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
            else n_pass++;
            n_total++;
            if ({out_quo, out_rem, out_dbz, out_ovf, out_tag} !== snap)
                $display("FAIL bp_stable[%0d]: got %h want %h", i,
                         {out_quo, out_rem, out_dbz, out_ovf, out_tag}, snap);
            else n_pass++;
        end
        drain();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_signed();
        int lat;
        run_req(8'hF9, 8'h02, 1'b1, 4'h1, 1'b0, lat);
        n_total++;
`ifdef DIVIDER_SIGNED_EN
        if ({out_quo, out_rem, out_ovf} !== {8'hFD, 8'hFF, 1'b0})
            $display("FAIL signed_m7_2: got q=%h r=%h ovf=%b want q=fd r=ff ovf=0", out_quo, out_rem, out_ovf);
        else n_pass++;
        drain();
        run_req(8'h80, 8'hFF, 1'b1, 4'h2, 1'b0, lat);
        n_total++;
        if ({lat == NSTEP + 1, out_quo, out_rem, out_ovf, out_dbz} !== {1'b1, 8'h80, 8'h00, 1'b1, 1'b0})
            $display("FAIL signed_ovf: got lat=%0d q=%h r=%h ovf=%b dbz=%b want lat=%0d q=80 r=00 ovf=1 dbz=0",
                     lat, out_quo, out_rem, out_ovf, out_dbz, NSTEP + 1);
        else n_pass++;
`else
        if ({out_quo, out_rem, out_ovf} !== {8'd124, 8'd1, 1'b0})
            $display("FAIL unsigned_f9_2: got q=%0d r=%0d ovf=%b want q=124 r=1 ovf=0", out_quo, out_rem, out_ovf);
        else n_pass++;
`endif
        drain();
    endtask

    task automatic test_abort();
        int lat;
        bit saw;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'd250;
        in_b     = 8'd3;
        in_tag   = 4'hC;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if ({out_valid, out_quo, out_rem, out_dbz, out_ovf, out_tag, in_ready} !== {1'b0, 22'd0, 1'b1})
            $display("FAIL abort_state: got v=%b q=%h r=%h dbz=%b ovf=%b tag=%h in_ready=%b want zeros, in_ready=1",
                     out_valid, out_quo, out_rem, out_dbz, out_ovf, out_tag, in_ready);
        else n_pass++;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        n_total++;
        if (saw !== 1'b0) $display("FAIL abort_no_output: got out_valid seen=%b want 0", saw);
        else n_pass++;
        run_req(8'd100, 8'd10, 1'b0, 4'h7, 1'b0, lat);
        n_total++;
        if ({lat == NSTEP + 1, out_quo, out_rem, out_tag} !== {1'b1, 8'd10, 8'd0, 4'h7})
            $display("FAIL abort_recover: got lat=%0d q=%0d r=%0d tag=%h want lat=%0d q=10 r=0 tag=7",
                     lat, out_quo, out_rem, out_tag, NSTEP + 1);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [TW-1:0] t;
        logic [W-1:0]  eq;
        logic [W-1:0]  er;
        logic          edbz;
        logic          eovf;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom);
            if (i == 0) begin a = 8'd0;   b = 8'd1;   end
            if (i == 1) begin a = 8'hFF;  b = 8'hFF;  end
            if (i == 2) begin a = 8'hFF;  b = 8'd1;   end
            if (i == 3) begin a = 8'd5;   b = 8'd200; end
            s = 1'($urandom);
            t = TW'($urandom);
            ref_div(a, b, s, eq, er, edbz, eovf);
            run_req(a, b, s, t, 1'($urandom), lat);
            n_total++;
            if (lat != (edbz ? 1 : NSTEP + 1))
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, edbz ? 1 : NSTEP + 1);
            else n_pass++;
            n_total++;
            if ({out_quo, out_rem, out_dbz, out_ovf, out_tag} !== {eq, er, edbz, eovf, t})
                $display("FAIL rand_result[%0d] a=%h b=%h s=%b: got q=%h r=%h dbz=%b ovf=%b tag=%h want q=%h r=%h dbz=%b ovf=%b tag=%h",
                         i, a, b, s, out_quo, out_rem, out_dbz, out_ovf, out_tag, eq, er, edbz, eovf, t);
            else n_pass++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_back_pressure();
        test_signed();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
